// File: rtl/sdram_rw_arbiter_if.sv
// Burst command handshake between the frame-buffer arbiter (master) and the
// SDRAM controller (slave).
interface sdram_rw_arbiter_if #(
    parameter int ADDR_W = 24
);
    logic              cmd_req;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [9:0]        cmd_len;
    logic              cmd_ack;
    logic              cmd_done;

    modport master (
        output cmd_req, cmd_wr, cmd_addr, cmd_len,
        input  cmd_ack, cmd_done
    );

    modport slave (
        input  cmd_req, cmd_wr, cmd_addr, cmd_len,
        output cmd_ack, cmd_done
    );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// Round-robin burst arbiter between the camera write FIFO and the VGA read FIFO,
// double-buffering whole frames in SDRAM.
module sdram_rw_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int BURST_LEN   = 256,
    parameter int FRAME_WORDS = 786432,
    parameter int BUF1_BASE   = 24'h0C0000,
    parameter int RD_THRESH   = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_done,
    input  logic [9:0]         wr_fifo_usedw,
    input  logic [9:0]         rd_fifo_usedw,
    input  logic               wr_frame_start,
    input  logic               rd_frame_start,
    sdram_rw_arbiter_if.master bus,
    output logic               wr_buf,
    output logic               rd_buf,
    output logic               busy
);

    typedef enum logic [1:0] {WAIT_INIT, ARB, REQ, BUSY} state_t;

    localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_A  = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BUF1_A   = ADDR_W'(BUF1_BASE);
    localparam logic [ADDR_W-1:0] RD_LAST  = FRAME_A - BURST_A;
    localparam logic [10:0]       BURST_U  = 11'(BURST_LEN);
    localparam logic [10:0]       THRESH_U = 11'(RD_THRESH);
    localparam logic [9:0]        LEN_C    = 10'(BURST_LEN);

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_off, rd_off, wr_off_n, rd_off_n, wr_sum, rd_sum;
    logic [ADDR_W-1:0] addr_q, grant_addr;
    logic [9:0]        len_q;
    logic              req_q, wr_q, last_wr;
    logic              done_buf, done_buf_n, wr_buf_n, rd_buf_n;
    logic              wr_pend, rd_pend, wr_pend_n, rd_pend_n;
    logic              wr_active, rd_active, done_evt, apply_wr, apply_rd;
    logic              wr_cand, rd_cand, grant, grant_wr;

    assign bus.cmd_req  = req_q;
    assign bus.cmd_wr   = wr_q;
    assign bus.cmd_addr = addr_q;
    assign bus.cmd_len  = len_q;
    assign busy         = (state == BUSY);

    // Frame-start pulses for the channel with a burst in flight wait for cmd_done,
    // so the burst completes against the buffer and offset it was issued with.
    always_comb begin
        wr_active = ((state == REQ) || (state == BUSY)) && wr_q;
        rd_active = ((state == REQ) || (state == BUSY)) && !wr_q;
        done_evt  = (state == BUSY) && bus.cmd_done;

        wr_sum = (done_evt && wr_q) ? wr_off + BURST_A : wr_off;
        rd_sum = rd_off;
        if (done_evt && !wr_q) begin
            rd_sum = (rd_off == RD_LAST) ? '0 : rd_off + BURST_A;
        end

        apply_wr = (wr_frame_start && !wr_active) ||
                   (done_evt && wr_q && (wr_pend || wr_frame_start));
        apply_rd = (rd_frame_start && !rd_active) ||
                   (done_evt && !wr_q && (rd_pend || rd_frame_start));

        wr_off_n   = wr_sum;
        wr_buf_n   = wr_buf;
        done_buf_n = done_buf;
        wr_pend_n  = wr_pend || wr_frame_start;
        if (apply_wr) begin
            wr_off_n  = '0;
            wr_pend_n = 1'b0;
            if (wr_sum == FRAME_A) begin
                done_buf_n = wr_buf;
                wr_buf_n   = !wr_buf;
            end
        end

        // A read frame start coinciding with a completed write frame picks up the new buffer.
        rd_off_n  = rd_sum;
        rd_buf_n  = rd_buf;
        rd_pend_n = rd_pend || rd_frame_start;
        if (apply_rd) begin
            rd_off_n  = '0;
            rd_pend_n = 1'b0;
            rd_buf_n  = done_buf_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        grant_wr = 1'b0;
        wr_cand  = ({1'b0, wr_fifo_usedw} >= BURST_U) && (wr_off_n < FRAME_A);
        rd_cand  = ({1'b0, rd_fifo_usedw} <= THRESH_U);
        case (state)
            WAIT_INIT: if (init_done) state_n = ARB;
            ARB: begin
                grant    = wr_cand || rd_cand;
                grant_wr = (wr_cand && rd_cand) ? !last_wr : wr_cand;
                if (grant) state_n = REQ;
            end
            REQ:  if (bus.cmd_ack)  state_n = BUSY;
            BUSY: if (bus.cmd_done) state_n = ARB;
            default: state_n = WAIT_INIT;
        endcase
        grant_addr = grant_wr ? ((wr_buf_n ? BUF1_A : '0) + wr_off_n)
                              : ((rd_buf_n ? BUF1_A : '0) + rd_off_n);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_INIT;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            wr_off   <= '0;
            rd_off   <= '0;
            wr_buf   <= 1'b0;
            rd_buf   <= 1'b1;
            done_buf <= 1'b1;
            last_wr  <= 1'b0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            wr_off   <= wr_off_n;
            rd_off   <= rd_off_n;
            wr_buf   <= wr_buf_n;
            rd_buf   <= rd_buf_n;
            done_buf <= done_buf_n;
            wr_pend  <= wr_pend_n;
            rd_pend  <= rd_pend_n;
            if (grant) begin
                req_q   <= 1'b1;
                wr_q    <= grant_wr;
                addr_q  <= grant_addr;
                len_q   <= LEN_C;
                last_wr <= grant_wr;
            end else if ((state == REQ) && bus.cmd_ack) begin
                req_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Self-checking bench for sdram_rw_arbiter: vector table, directed frame
// sequences and a randomized run against a transaction-level model.
module tb_sdram_rw_arbiter;

    localparam int          ADDR_W = 24;
    localparam int          BURST  = 256;
    localparam int          FRAME  = 786432;
    localparam logic [23:0] BUF1   = 24'h0C0000;

    typedef struct {
        logic [9:0]  wr_usedw;
        logic [9:0]  rd_usedw;
        bit          exp_req;
        bit          exp_wr;
        logic [23:0] exp_addr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, init_done, wr_fs, rd_fs;
    logic [9:0] wr_usedw, rd_usedw;
    logic       wr_buf, rd_buf, busy;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[10];

    int m_wr_off, m_rd_off;
    bit m_wr_buf, m_rd_buf, m_done_buf, m_last_wr, m_wr_pend, m_rd_pend;

    sdram_rw_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sdram_rw_arbiter #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST), .FRAME_WORDS(FRAME),
        .BUF1_BASE(24'h0C0000), .RD_THRESH(256)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .wr_fifo_usedw(wr_usedw), .rd_fifo_usedw(rd_usedw),
        .wr_frame_start(wr_fs), .rd_frame_start(rd_fs),
        .bus(bus), .wr_buf(wr_buf), .rd_buf(rd_buf), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Frame-level model: offsets and buffer roles move only on grants, completions and frame starts.
    task automatic model_reset();
        m_wr_off = 0; m_rd_off = 0;
        m_wr_buf = 1'b0; m_rd_buf = 1'b1; m_done_buf = 1'b1;
        m_last_wr = 1'b0; m_wr_pend = 1'b0; m_rd_pend = 1'b0;
    endtask

    task automatic model_wr_start();
        if (m_wr_off == FRAME) begin
            m_done_buf = m_wr_buf;
            m_wr_buf   = !m_wr_buf;
        end
        m_wr_off = 0;
    endtask

    task automatic model_rd_start();
        m_rd_buf = m_done_buf;
        m_rd_off = 0;
    endtask

    task automatic model_done(input bit was_wr);
        if (was_wr) begin
            m_wr_off += BURST;
            if (m_wr_pend) begin m_wr_pend = 1'b0; model_wr_start(); end
        end else begin
            m_rd_off = (m_rd_off + BURST) % FRAME;
            if (m_rd_pend) begin m_rd_pend = 1'b0; model_rd_start(); end
        end
    endtask

    function automatic logic [31:0] model_addr(input bit is_wr);
        if (is_wr) return (m_wr_buf ? 32'(BUF1) : 32'd0) + 32'(m_wr_off);
        return (m_rd_buf ? 32'(BUF1) : 32'd0) + 32'(m_rd_off);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req"},    bus.cmd_req,  0);
        check_output({tag, "_wr"},     bus.cmd_wr,   0);
        check_output({tag, "_addr"},   bus.cmd_addr, 0);
        check_output({tag, "_len"},    bus.cmd_len,  0);
        check_output({tag, "_busy"},   busy,         0);
        check_output({tag, "_wr_buf"}, wr_buf,       0);
        check_output({tag, "_rd_buf"}, rd_buf,       1);
    endtask

    task automatic do_reset(input bit init, input bit check);
        rst = 1'b1; init_done = init;
        wr_usedw = 10'd0; rd_usedw = 10'd1023; wr_fs = 1'b0; rd_fs = 1'b0;
        bus.cmd_ack = 1'b0; bus.cmd_done = 1'b0;
        repeat (2) tick();
        if (check) check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cmd_req) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check_output("req_timeout", bus.cmd_req, 1);
    endtask

    task automatic complete_burst(input int ack_dly, input int done_dly);
        repeat (ack_dly) tick();
        bus.cmd_ack = 1'b1; tick(); bus.cmd_ack = 1'b0;
        repeat (done_dly) tick();
        bus.cmd_done = 1'b1; tick(); bus.cmd_done = 1'b0;
    endtask

    task automatic fill_writes(input int n, input logic [23:0] start, output int bad);
        bit ok;
        bad = 0;
        wr_usedw = 10'd1023; rd_usedw = 10'd1023;
        for (int i = 0; i < n; i++) begin
            wait_req(ok);
            if (!ok) begin bad++; break; end
            if (!bus.cmd_wr || bus.cmd_addr != start + 24'(i * BURST)) bad++;
            complete_burst(0, 0);
        end
        wr_usedw = 10'd0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        bit ok, seen;
        wr_usedw = v.wr_usedw; rd_usedw = v.rd_usedw;
        if (v.exp_req) begin
            wait_req(ok);
            if (ok) begin
                check_output($sformatf("vec%0d_wr", idx),   bus.cmd_wr,   32'(v.exp_wr));
                check_output($sformatf("vec%0d_addr", idx), bus.cmd_addr, 32'(v.exp_addr));
                check_output($sformatf("vec%0d_len", idx),  bus.cmd_len,  256);
                complete_burst(1, 2);
            end
        end else begin
            // Stray ack/done while idle must not disturb offsets or state.
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                bus.cmd_ack = (i == 2); bus.cmd_done = (i == 2);
                tick();
                seen |= bus.cmd_req;
            end
            bus.cmd_ack = 1'b0; bus.cmd_done = 1'b0;
            check_output($sformatf("vec%0d_idle", idx), seen, 0);
        end
    endtask

    task automatic random_test(input int n);
        bit ok, mw, mr, exp_wr, stable, seen;
        logic [31:0] exp_addr;
        logic [2:0]  fs;
        int d, b;
        for (int it = 0; it < n; it++) begin
            wr_usedw = 10'($urandom_range(200, 320));
            rd_usedw = 10'($urandom_range(200, 320));
            mw = (wr_usedw >= BURST) && (m_wr_off < FRAME);
            mr = (rd_usedw <= 256);
            if (!mw && !mr) begin
                seen = 1'b0;
                repeat (4) begin tick(); seen |= bus.cmd_req; end
                check_output("rand_idle", seen, 0);
                continue;
            end
            exp_wr   = (mw && mr) ? !m_last_wr : mw;
            exp_addr = model_addr(exp_wr);
            wait_req(ok);
            if (!ok) break;
            check_output("rand_wr", bus.cmd_wr, 32'(exp_wr));
            check_output("rand_addr", bus.cmd_addr, exp_addr);
            m_last_wr = exp_wr;
            d = $urandom_range(0, 3);
            stable = 1'b1;
            repeat (d) begin
                tick();
                if (!bus.cmd_req || bus.cmd_addr != exp_addr[23:0]) stable = 1'b0;
            end
            check_output("rand_hold", stable, 1);
            bus.cmd_ack = 1'b1; tick(); bus.cmd_ack = 1'b0;
            check_output("rand_req_drop", bus.cmd_req, 0);
            check_output("rand_busy", busy, 1);
            fs = 3'($urandom_range(0, 7));
            wr_fs = fs[0]; rd_fs = fs[1];
            if (fs[0]) begin if (exp_wr) m_wr_pend = 1'b1; else model_wr_start(); end
            if (fs[1]) begin if (!exp_wr) m_rd_pend = 1'b1; else model_rd_start(); end
            tick();
            wr_fs = 1'b0; rd_fs = 1'b0;
            b = $urandom_range(0, 3);
            repeat (b) tick();
            check_output("rand_addr_busy", bus.cmd_addr, exp_addr);
            bus.cmd_done = 1'b1; tick(); bus.cmd_done = 1'b0;
            model_done(exp_wr);
            check_output("rand_wr_buf", wr_buf, 32'(m_wr_buf));
            check_output("rand_rd_buf", rd_buf, 32'(m_rd_buf));
        end
    endtask

    initial begin
        bit ok, seen, stable;
        int bad;
        logic [23:0] held_addr;

        vecs[0] = '{10'd300,  10'd100,  1'b1, 1'b1, 24'h000000};
        vecs[1] = '{10'd300,  10'd100,  1'b1, 1'b0, 24'h0C0000};
        vecs[2] = '{10'd300,  10'd100,  1'b1, 1'b1, 24'h000100};
        vecs[3] = '{10'd300,  10'd100,  1'b1, 1'b0, 24'h0C0100};
        vecs[4] = '{10'd300,  10'd100,  1'b1, 1'b1, 24'h000200};
        vecs[5] = '{10'd255,  10'd256,  1'b1, 1'b0, 24'h0C0200};
        vecs[6] = '{10'd256,  10'd257,  1'b1, 1'b1, 24'h000300};
        vecs[7] = '{10'd256,  10'd256,  1'b1, 1'b0, 24'h0C0300};
        vecs[8] = '{10'd0,    10'd1023, 1'b0, 1'b0, 24'h000000};
        vecs[9] = '{10'd1023, 10'd0,    1'b1, 1'b1, 24'h000400};

        // Requests stay suppressed until the controller reports init complete.
        do_reset(1'b0, 1'b1);
        wr_usedw = 10'd300; rd_usedw = 10'd1000;
        seen = 1'b0;
        repeat (50) begin tick(); seen |= bus.cmd_req; end
        check_output("init_hold", seen, 0);
        init_done = 1'b1;
        repeat (2) tick();
        check_output("init_req", bus.cmd_req, 1);
        check_output("init_wr", bus.cmd_wr, 1);
        check_output("init_addr", bus.cmd_addr, 0);
        check_output("init_len", bus.cmd_len, 256);
        complete_burst(0, 1);

        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], i);

        // Withheld ack, then reset in the middle of a burst.
        do_reset(1'b1, 1'b0);
        wr_usedw = 10'd300; rd_usedw = 10'd1000;
        wait_req(ok);
        held_addr = bus.cmd_addr;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!bus.cmd_req || !bus.cmd_wr || bus.cmd_addr != held_addr) stable = 1'b0;
        end
        check_output("ack_hold_stable", stable, 1);
        check_output("ack_hold_addr", held_addr, 0);
        bus.cmd_ack = 1'b1; tick(); bus.cmd_ack = 1'b0;
        check_output("busy_set", busy, 1);
        rst = 1'b1; tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        wait_req(ok);
        check_output("post_reset_wr", bus.cmd_wr, 1);
        check_output("post_reset_addr", bus.cmd_addr, 0);
        complete_burst(0, 0);

        // Partial frame discarded.
        do_reset(1'b1, 1'b0);
        fill_writes(10, 24'h0, bad);
        check_output("partial_fill_bad", bad, 0);
        wr_fs = 1'b1; tick(); wr_fs = 1'b0;
        check_output("partial_wr_buf", wr_buf, 0);
        wr_usedw = 10'd300;
        wait_req(ok);
        check_output("partial_next_wr", bus.cmd_wr, 1);
        check_output("partial_next_addr", bus.cmd_addr, 0);
        complete_burst(0, 0);

        // Full frame, buffer swap, pending read frame start, simultaneous frame starts.
        do_reset(1'b1, 1'b0);
        fill_writes(3072, 24'h0, bad);
        check_output("frame0_fill_bad", bad, 0);
        wr_usedw = 10'd1023;
        seen = 1'b0;
        repeat (6) begin tick(); seen |= bus.cmd_req; end
        check_output("frame_saturated", seen, 0);
        wr_usedw = 10'd0; wr_fs = 1'b1; tick(); wr_fs = 1'b0;
        check_output("swap_wr_buf", wr_buf, 1);
        rd_usedw = 10'd0;
        wait_req(ok);
        check_output("rd_before_wr", bus.cmd_wr, 0);
        check_output("rd_before_addr", bus.cmd_addr, 32'(BUF1));
        rd_usedw = 10'd1023;
        bus.cmd_ack = 1'b1; tick(); bus.cmd_ack = 1'b0;
        rd_fs = 1'b1; tick(); rd_fs = 1'b0;
        check_output("rd_pending_buf", rd_buf, 1);
        check_output("rd_pending_addr", bus.cmd_addr, 32'(BUF1));
        bus.cmd_done = 1'b1; tick(); bus.cmd_done = 1'b0;
        check_output("rd_applied_buf", rd_buf, 0);
        rd_usedw = 10'd0;
        wait_req(ok);
        check_output("rd_new_wr", bus.cmd_wr, 0);
        check_output("rd_new_addr", bus.cmd_addr, 0);
        rd_usedw = 10'd1023;
        complete_burst(0, 0);
        wr_usedw = 10'd1023;
        wait_req(ok);
        check_output("wr_buf1_wr", bus.cmd_wr, 1);
        check_output("wr_buf1_addr", bus.cmd_addr, 32'(BUF1));
        complete_burst(0, 0);
        fill_writes(3071, BUF1 + 24'd256, bad);
        check_output("frame1_fill_bad", bad, 0);
        wr_fs = 1'b1; rd_fs = 1'b1; tick(); wr_fs = 1'b0; rd_fs = 1'b0;
        check_output("simul_wr_buf", wr_buf, 0);
        check_output("simul_rd_buf", rd_buf, 1);
        rd_usedw = 10'd0;
        wait_req(ok);
        check_output("simul_rd_addr", bus.cmd_addr, 32'(BUF1));
        rd_usedw = 10'd1023;
        complete_burst(0, 0);

        do_reset(1'b1, 1'b0);
        random_test(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
